// File: rtl/mac_if.sv
// Handshake bundle between an operand producer, the MAC accumulator and the
// consumer of its per-frame results.
interface mac_if #(
  parameter int N1    = 8,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [N1-1:0]    in_a;
  logic [N1-1:0]    in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic [LEN_W-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, out_count
  );
endinterface

// File: rtl/mac_accumulator.sv
// Frame-based unsigned multiply-accumulate: one registered product stage feeding
// a saturating accumulator and pair counter, with a RUN/DRAIN/DONE frame FSM.
module mac_accumulator #(
  parameter int N1    = 8,
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  mac_if.slave bus
);

  localparam logic [1:0]       RUN     = 2'd0;
  localparam logic [1:0]       DRAIN   = 2'd1;
  localparam logic [1:0]       DONE    = 2'd2;
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              accept_s;
  logic              consume_s;
  logic [2*N1-1:0]   prod_s;
  logic              p_valid_r;
  logic [2*N1-1:0]   p_prod_r;
  logic [ACC_W:0]    sum_s;
  logic [ACC_W-1:0]  acc_r;
  logic              ovf_r;
  logic [LEN_W-1:0]  count_r;

  assign accept_s  = bus.in_valid && in_ready_r;
  assign consume_s = out_valid_r && bus.out_ready;
  assign prod_s    = {{N1{1'b0}}, bus.in_a} * {{N1{1'b0}}, bus.in_b};
  // One extra bit catches the carry out that signals saturation.
  assign sum_s     = {1'b0, acc_r} + {{(ACC_W + 1 - 2*N1){1'b0}}, p_prod_r};

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_acc   = acc_r;
  assign bus.out_ovf   = ovf_r;
  assign bus.out_count = count_r;

  // Frame FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (accept_s && bus.in_last) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DRAIN: state_nxt_s = DONE;
      DONE: begin
        if (consume_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // State register with handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == RUN);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // Product stage, loaded on every accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_r <= 1'b0;
      p_prod_r  <= '0;
    end else begin
      p_valid_r <= accept_s;
      if (accept_s) begin
        p_prod_r <= prod_s;
      end
    end
  end

  // Saturating accumulator, sticky overflow and saturating pair count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= '0;
      ovf_r   <= 1'b0;
      count_r <= '0;
    end else if (consume_s) begin
      acc_r   <= '0;
      ovf_r   <= 1'b0;
      count_r <= '0;
    end else if (p_valid_r) begin
      if (sum_s[ACC_W]) begin
        acc_r <= ACC_MAX;
        ovf_r <= 1'b1;
      end else begin
        acc_r <= sum_s[ACC_W-1:0];
      end
      if (count_r != LEN_MAX) begin
        count_r <= count_r + LEN_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a behavioural model queues the expected
// frame result per last beat; a negedge monitor compares whenever out_valid is up.
module tb_mac_accumulator;

  localparam int     N1      = 8;
  localparam int     ACC_W   = 24;
  localparam int     LEN_W   = 8;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;
  localparam int     LEN_MAX = (1 << LEN_W) - 1;

  typedef struct {
    longint acc;
    logic   ovf;
    int     cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  longint m_acc;
  logic   m_ovf;
  int     m_cnt;

  always #5 clk = ~clk;

  mac_if #(.N1(N1), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  mac_accumulator #(.N1(N1), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // Drive one beat, wait for acceptance, then fold it into the reference model.
  task automatic send(input int a, input int b, input logic last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a     = a[N1-1:0];
    bus.in_b     = b[N1-1:0];
    bus.in_last  = last;
    n = 0;
    while (!bus.in_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      check_val("send_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    m_acc = m_acc + longint'(a) * longint'(b);
    if (m_acc > ACC_MAX) begin
      m_acc = ACC_MAX;
      m_ovf = 1'b1;
    end
    if (m_cnt < LEN_MAX) m_cnt++;
    if (last) begin
      exp_q.push_back('{acc: m_acc, ovf: m_ovf, cnt: m_cnt});
      model_reset();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  // Result monitor: compares every cycle the result is presented, pops on handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_out", 64'(exp_q.size()), 64'd1);
      end else begin
        check_val("out_acc",   64'(bus.out_acc),   64'(exp_q[0].acc));
        check_val("out_ovf",   64'(bus.out_ovf),   64'(exp_q[0].ovf));
        check_val("out_count", 64'(bus.out_count), 64'(exp_q[0].cnt));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd3;
    bus.in_b      = 8'd3;
    bus.in_last   = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_acc",   64'(bus.out_acc),   64'd0);
    check_val("rst_out_ovf",   64'(bus.out_ovf),   64'd0);
    check_val("rst_out_count", 64'(bus.out_count), 64'd0);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("no_accept_in_reset", 64'(bus.out_valid), 64'd0);

    // Single full-scale beat and the two-edge latency.
    send(255, 255, 1'b1);
    check_val("lat_ready_low", 64'(bus.in_ready),  64'd0);
    check_val("lat_e0",        64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check_val("lat_e1",        64'(bus.out_valid), 64'd1);
    wait_idle();
    check_val("ready_after_hs", 64'(bus.in_ready), 64'd1);

    // Back-to-back four-beat frame.
    send(1, 2, 1'b0);
    send(3, 4, 1'b0);
    send(5, 6, 1'b0);
    send(7, 8, 1'b1);
    check_val("b2b_ready_low", 64'(bus.in_ready), 64'd0);
    wait_idle();

    // Long frame: sum and count both saturate.
    for (int i = 0; i < 259; i++) send(255, 255, 1'b0);
    send(255, 255, 1'b1);
    wait_idle();

    // Consumer stalls in DONE while producer keeps offering a beat.
    bus.out_ready = 1'b0;
    send(9, 9, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd50;
    bus.in_b     = 8'd50;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("hold_ready_low", 64'(bus.in_ready),  64'd0);
      check_val("hold_valid",     64'(bus.out_valid), 64'd1);
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    send(1, 2, 1'b1);
    wait_idle();

    // Reset mid-frame discards the partial sum.
    send(10, 10, 1'b0);
    send(10, 10, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_val("async_rst_acc",   64'(bus.out_acc),   64'd0);
    check_val("async_rst_count", 64'(bus.out_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(2, 3, 1'b1);
    wait_idle();

    // Bubbles inside a frame, then a fresh frame starting from zero.
    send(4, 4, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    send(4, 4, 1'b1);
    send(1, 1, 1'b1);
    wait_idle();

    // A few random frames with random gaps.
    for (int f = 0; f < 4; f++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int k = 0; k < len; k++) begin
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), (k == len - 1));
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
      end
    end
    wait_idle();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001: Parameter N1, default 8, is the operand width in bits.
REQ-002: Parameter ACC_W, default 24, is the accumulator width in bits (ACC_W >= 2*N1).
REQ-003: Parameter LEN_W, default 8, is the element-count width in bits.
REQ-004: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005: rst_n  input  1  asynchronous, active-low reset.
REQ-006: in_valid  input  1  operand pair valid.
REQ-007: in_ready  output  1  block accepts an operand pair this cycle.
REQ-008: in_a  input  N1  unsigned multiplicand.
REQ-009: in_b  input  N1  unsigned multiplier.
REQ-010: in_last  input  1  marks the final pair of a frame; qualified by in_valid.
REQ-011: out_valid  output  1  frame result valid.
REQ-012: out_ready  input  1  consumer accepts the result.
REQ-013: out_acc  output  ACC_W  saturated sum of products for the frame.
REQ-014: out_ovf  output  1  the frame sum exceeded 2^ACC_W-1.
REQ-015: out_count  output  LEN_W  number of pairs in the frame, saturating at 2^LEN_W-1.

Function
REQ-016: An input beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-017: The product in_a*in_b SHALL be computed combinationally as an unsigned 2*N1-bit value and registered, with its valid and last flags, in a product stage on the accepting edge.
REQ-018: On the next edge, a valid product stage SHALL be zero-extended and added to the accumulator, and the count SHALL be incremented.
REQ-019: If the sum exceeds 2^ACC_W-1, the accumulator SHALL saturate to 2^ACC_W-1 and the ovf flag SHALL be set; ovf SHALL remain set until the frame is consumed.
REQ-020: The count SHALL saturate at 2^LEN_W-1 and SHALL not wrap.
REQ-021: The FSM SHALL have states RUN, DRAIN and DONE; in_ready SHALL equal (state==RUN).
REQ-022: RUN -> DRAIN on acceptance of a beat with in_last=1; otherwise remain in RUN.
REQ-023: DRAIN -> DONE unconditionally on the next edge, when the last product is accumulated.
REQ-024: In DONE, out_valid SHALL be 1, and out_acc, out_ovf and out_count SHALL hold stable until out_valid && out_ready.
REQ-025: On the output handshake: DONE -> RUN; accumulator, ovf and count SHALL clear to 0; the product stage SHALL be empty.
REQ-026: In RUN, non-last beats SHALL be accepted back-to-back at one per cycle; in_valid gaps SHALL insert bubbles without altering the sum.
REQ-027: Latency: with the last beat accepted at edge E0, out_valid SHALL be high in the cycle after edge E0+1 (two edges).
REQ-028: If in_valid and out_ready are both high in DONE, only the output handshake SHALL occur; the input SHALL not be accepted until RUN (next cycle).
REQ-029: A frame SHALL contain at least one beat; in_last SHALL be ignored when in_valid=0.
REQ-030: out_acc, out_ovf and out_count SHALL be driven from the registered accumulator state in all states; they are meaningful only while out_valid=1.

Reset
REQ-031: rst_n low SHALL immediately force state=RUN, the product stage empty, accumulator=0, ovf=0 and count=0.
REQ-032: Reset values: in_ready=1, out_valid=0, out_acc=0, out_ovf=0, out_count=0.
REQ-033: Reset asserted mid-frame or in DONE SHALL discard the partial or pending result; the first frame after release SHALL start from zero.
REQ-034: No beat SHALL be accepted while rst_n is low.

Verification
REQ-035: Single beat a=255, b=255, last=1 -> out_valid two edges later; out_acc=65025, out_count=1, out_ovf=0.
REQ-036: Back-to-back beats (1,2),(3,4),(5,6),(7,8) with last on the 4th -> out_acc=100, out_count=4; in_ready low from acceptance of the last beat until the output handshake.
REQ-037: 260 beats of (255,255) -> out_acc=16777215, out_ovf=1, out_count=255.
REQ-038: out_ready held low for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no beat accepted; the next frame result excludes those held beats.
REQ-039: Two beats (10,10) followed by a rst_n pulse, then beat (2,3) last -> out_acc=6, out_count=1.
REQ-040: Beats (4,4),gap,gap,(4,4) last -> out_acc=32, out_count=2; the following frame (1,1) last -> out_acc=1, out_count=1, out_ovf=0.
